// File: rtl/bsg_mcl_axil_fifos_slave.sv
// Host-side adapter for manycore-initiated traffic: serializes request packets into
// AXI-Lite words and assembles host-written AXI-Lite words into response packets.
module bsg_mcl_axil_fifos_slave #(
  parameter int unsigned fifo_width_p      = 128,
  parameter int unsigned axil_data_width_p = 32,
  parameter int unsigned req_els_p         = 4,
  parameter int unsigned rsp_els_p         = 4,
  localparam int unsigned ratio_lp         = fifo_width_p / axil_data_width_p,
  localparam int unsigned req_occ_w_lp     = $clog2(ratio_lp * req_els_p + 1),
  localparam int unsigned rsp_vac_w_lp     = $clog2(ratio_lp * rsp_els_p + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,

  input  logic [fifo_width_p-1:0]      fifo_req_i,
  input  logic                         fifo_req_v_i,
  output logic                         fifo_req_ready_o,

  output logic [axil_data_width_p-1:0] axil_req_o,
  output logic                         axil_req_v_o,
  input  logic                         axil_req_ready_i,

  input  logic [axil_data_width_p-1:0] axil_rsp_i,
  input  logic                         axil_rsp_v_i,
  output logic                         axil_rsp_ready_o,

  output logic [fifo_width_p-1:0]      fifo_rsp_o,
  output logic                         fifo_rsp_v_o,
  input  logic                         fifo_rsp_ready_i,

  output logic [req_occ_w_lp-1:0]      req_occupancy_o,
  output logic [rsp_vac_w_lp-1:0]      rsp_vacancy_o
);

  localparam int unsigned req_cnt_w_lp = $clog2(req_els_p + 1);
  localparam int unsigned rsp_cnt_w_lp = $clog2(rsp_els_p + 1);
  localparam int unsigned req_ptr_w_lp = (req_els_p > 1) ? $clog2(req_els_p) : 1;
  localparam int unsigned rsp_ptr_w_lp = (rsp_els_p > 1) ? $clog2(rsp_els_p) : 1;
  localparam int unsigned idx_w_lp     = (ratio_lp > 1) ? $clog2(ratio_lp) : 1;

  // Parameter sanity: packets must split into whole words and both buffers must exist
  if ((fifo_width_p % axil_data_width_p) != 0 || req_els_p == 0 || rsp_els_p == 0) begin : g_bad_params
    $fatal(1, "bsg_mcl_axil_fifos_slave: illegal parameter combination");
  end

  function automatic logic [req_ptr_w_lp-1:0] req_ptr_inc(input logic [req_ptr_w_lp-1:0] p);
    return (p == req_ptr_w_lp'(req_els_p - 1)) ? '0 : p + req_ptr_w_lp'(1);
  endfunction

  function automatic logic [rsp_ptr_w_lp-1:0] rsp_ptr_inc(input logic [rsp_ptr_w_lp-1:0] p);
    return (p == rsp_ptr_w_lp'(rsp_els_p - 1)) ? '0 : p + rsp_ptr_w_lp'(1);
  endfunction

  // ---------------- request path ----------------
  logic [fifo_width_p-1:0] req_mem_q [req_els_p];
  logic [req_ptr_w_lp-1:0] req_wptr_q, req_wptr_d;
  logic [req_ptr_w_lp-1:0] req_rptr_q, req_rptr_d;
  logic [req_cnt_w_lp-1:0] req_cnt_q, req_cnt_d;
  logic [idx_w_lp-1:0]     rd_idx_q, rd_idx_d;
  logic                    req_push, req_xfer, req_pop;

  assign fifo_req_ready_o = (req_cnt_q != req_cnt_w_lp'(req_els_p));
  assign axil_req_v_o     = (req_cnt_q != '0);
  assign axil_req_o       = req_mem_q[req_rptr_q][rd_idx_q * axil_data_width_p +: axil_data_width_p];
  assign req_occupancy_o  = req_occ_w_lp'(req_cnt_q) * req_occ_w_lp'(ratio_lp)
                          - req_occ_w_lp'(rd_idx_q);

  // Push/serialize bookkeeping; the final word of the head packet pops it
  always_comb begin
    req_wptr_d = req_wptr_q;
    req_rptr_d = req_rptr_q;
    req_cnt_d  = req_cnt_q;
    rd_idx_d   = rd_idx_q;
    req_push   = fifo_req_v_i & fifo_req_ready_o;
    req_xfer   = axil_req_v_o & axil_req_ready_i;
    req_pop    = req_xfer & (rd_idx_q == idx_w_lp'(ratio_lp - 1));

    if (req_push) req_wptr_d = req_ptr_inc(req_wptr_q);
    if (req_xfer) rd_idx_d = req_pop ? '0 : rd_idx_q + idx_w_lp'(1);
    if (req_pop)  req_rptr_d = req_ptr_inc(req_rptr_q);

    case ({req_push, req_pop})
      2'b10:   req_cnt_d = req_cnt_q + req_cnt_w_lp'(1);
      2'b01:   req_cnt_d = req_cnt_q - req_cnt_w_lp'(1);
      default: req_cnt_d = req_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (req_push) req_mem_q[req_wptr_q] <= fifo_req_i;
  end

  // ---------------- response path ----------------
  logic [fifo_width_p-1:0] rsp_mem_q [rsp_els_p];
  logic [rsp_ptr_w_lp-1:0] rsp_wptr_q, rsp_wptr_d;
  logic [rsp_ptr_w_lp-1:0] rsp_rptr_q, rsp_rptr_d;
  logic [rsp_cnt_w_lp-1:0] rsp_cnt_q, rsp_cnt_d;
  logic [idx_w_lp-1:0]     wr_idx_q, wr_idx_d;
  logic                    rsp_wr, rsp_commit, rsp_pop;

  assign axil_rsp_ready_o = (rsp_cnt_q != rsp_cnt_w_lp'(rsp_els_p));
  assign fifo_rsp_v_o     = (rsp_cnt_q != '0);
  assign fifo_rsp_o       = rsp_mem_q[rsp_rptr_q];
  assign rsp_vacancy_o    = (rsp_vac_w_lp'(rsp_els_p) - rsp_vac_w_lp'(rsp_cnt_q))
                          * rsp_vac_w_lp'(ratio_lp) - rsp_vac_w_lp'(wr_idx_q);

  // Partial entries stay uncommitted, so only whole packets are counted in rsp_cnt
  always_comb begin
    rsp_wptr_d = rsp_wptr_q;
    rsp_rptr_d = rsp_rptr_q;
    rsp_cnt_d  = rsp_cnt_q;
    wr_idx_d   = wr_idx_q;
    rsp_wr     = axil_rsp_v_i & axil_rsp_ready_o;
    rsp_commit = rsp_wr & (wr_idx_q == idx_w_lp'(ratio_lp - 1));
    rsp_pop    = fifo_rsp_v_o & fifo_rsp_ready_i;

    if (rsp_wr)     wr_idx_d = rsp_commit ? '0 : wr_idx_q + idx_w_lp'(1);
    if (rsp_commit) rsp_wptr_d = rsp_ptr_inc(rsp_wptr_q);
    if (rsp_pop)    rsp_rptr_d = rsp_ptr_inc(rsp_rptr_q);

    case ({rsp_commit, rsp_pop})
      2'b10:   rsp_cnt_d = rsp_cnt_q + rsp_cnt_w_lp'(1);
      2'b01:   rsp_cnt_d = rsp_cnt_q - rsp_cnt_w_lp'(1);
      default: rsp_cnt_d = rsp_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rsp_wr) rsp_mem_q[rsp_wptr_q][wr_idx_q * axil_data_width_p +: axil_data_width_p] <= axil_rsp_i;
  end

  // Control state; reset drops every buffered or partially transferred packet
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      req_wptr_q <= '0;
      req_rptr_q <= '0;
      req_cnt_q  <= '0;
      rd_idx_q   <= '0;
      rsp_wptr_q <= '0;
      rsp_rptr_q <= '0;
      rsp_cnt_q  <= '0;
      wr_idx_q   <= '0;
    end else begin
      req_wptr_q <= req_wptr_d;
      req_rptr_q <= req_rptr_d;
      req_cnt_q  <= req_cnt_d;
      rd_idx_q   <= rd_idx_d;
      rsp_wptr_q <= rsp_wptr_d;
      rsp_rptr_q <= rsp_rptr_d;
      rsp_cnt_q  <= rsp_cnt_d;
      wr_idx_q   <= wr_idx_d;
    end
  end

endmodule

// File: tb/tb_bsg_mcl_axil_fifos_slave.sv
// Self-checking bench for bsg_mcl_axil_fifos_slave: vector table for request
// serialization plus scoreboarded multi-cycle sequences for both paths.
module tb_bsg_mcl_axil_fifos_slave;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic [127:0] fifo_req_i;
  logic         fifo_req_v_i;
  logic         fifo_req_ready_o;
  logic [31:0]  axil_req_o;
  logic         axil_req_v_o;
  logic         axil_req_ready_i;
  logic [31:0]  axil_rsp_i;
  logic         axil_rsp_v_i;
  logic         axil_rsp_ready_o;
  logic [127:0] fifo_rsp_o;
  logic         fifo_rsp_v_o;
  logic         fifo_rsp_ready_i;
  logic [4:0]   req_occupancy_o;
  logic [4:0]   rsp_vacancy_o;

  bsg_mcl_axil_fifos_slave dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .fifo_req_i       (fifo_req_i),
    .fifo_req_v_i     (fifo_req_v_i),
    .fifo_req_ready_o (fifo_req_ready_o),
    .axil_req_o       (axil_req_o),
    .axil_req_v_o     (axil_req_v_o),
    .axil_req_ready_i (axil_req_ready_i),
    .axil_rsp_i       (axil_rsp_i),
    .axil_rsp_v_i     (axil_rsp_v_i),
    .axil_rsp_ready_o (axil_rsp_ready_o),
    .fifo_rsp_o       (fifo_rsp_o),
    .fifo_rsp_v_o     (fifo_rsp_v_o),
    .fifo_rsp_ready_i (fifo_rsp_ready_i),
    .req_occupancy_o  (req_occupancy_o),
    .rsp_vacancy_o    (rsp_vacancy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic         req_v;
    logic [127:0] req_data;
    logic         host_rdy;
    logic         exp_v;
    logic [31:0]  exp_word;
    logic [4:0]   exp_occ;
    logic         exp_in_rdy;
  } vec_t;

  vec_t         tbl [6];
  int           n_chk  = 0;
  int           n_pass = 0;
  logic [31:0]  req_q [$];
  logic [127:0] rsp_q [$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] req_word(input int k, input int j);
    return 32'hA000_0000 + 32'(k) * 32'h10 + 32'(j);
  endfunction

  function automatic logic [31:0] rsp_word(input int p, input int j);
    return 32'hC0DE_0000 + 32'(p) * 32'h100 + 32'(j);
  endfunction

  function automatic logic [127:0] req_pkt(input int k);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) r[32*j +: 32] = req_word(k, j);
    return r;
  endfunction

  function automatic logic [127:0] rsp_pkt(input int p);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) r[32*j +: 32] = rsp_word(p, j);
    return r;
  endfunction

  task automatic push_req_words(input logic [127:0] pkt);
    for (int j = 0; j < 4; j++) req_q.push_back(pkt[32*j +: 32]);
  endtask

  task automatic write_rsp_pkt(input int p);
    for (int j = 0; j < 4; j++) begin
      axil_rsp_v_i = 1'b1;
      axil_rsp_i   = rsp_word(p, j);
      step();
    end
    rsp_q.push_back(rsp_pkt(p));
    axil_rsp_v_i = 1'b0;
  endtask

  task automatic drain_req(input int budget);
    repeat (budget) begin
      @(negedge clk_i);
      if (req_q.size() == 0 && !axil_req_v_o) break;
      step();
    end
  endtask

  task automatic drain_rsp(input int budget);
    repeat (budget) begin
      @(negedge clk_i);
      if (rsp_q.size() == 0 && !fifo_rsp_v_o) break;
      step();
    end
  endtask

  // Scoreboard: every host word and endpoint packet transfer is matched in order
  always @(negedge clk_i) begin
    if (reset_n_i) begin
      if (axil_req_v_o && axil_req_ready_i) begin
        if (req_q.size() == 0) begin
          n_chk++;
          $display("FAIL req_unexpected: got word %0h, expected no transfer", axil_req_o);
        end else chk("req_word", 128'(axil_req_o), 128'(req_q.pop_front()));
      end
      if (fifo_rsp_v_o && fifo_rsp_ready_i) begin
        if (rsp_q.size() == 0) begin
          n_chk++;
          $display("FAIL rsp_unexpected: got packet %0h, expected no transfer", fifo_rsp_o);
        end else chk("rsp_pkt", fifo_rsp_o, rsp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    logic [127:0] p0;

    fifo_req_v_i = 1'b0; fifo_req_i = '0; axil_req_ready_i = 1'b0;
    axil_rsp_v_i = 1'b0; axil_rsp_i = '0; fifo_rsp_ready_i = 1'b0;
    reset_n_i = 1'b1;

    p0 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    tbl[0] = '{1'b1, p0,   1'b1, 1'b0, 32'h0,         5'd0, 1'b1};
    tbl[1] = '{1'b0, 128'h0, 1'b1, 1'b1, 32'h1111_1111, 5'd4, 1'b1};
    tbl[2] = '{1'b0, 128'h0, 1'b1, 1'b1, 32'h2222_2222, 5'd3, 1'b1};
    tbl[3] = '{1'b0, 128'h0, 1'b1, 1'b1, 32'h3333_3333, 5'd2, 1'b1};
    tbl[4] = '{1'b0, 128'h0, 1'b1, 1'b1, 32'h4444_4444, 5'd1, 1'b1};
    tbl[5] = '{1'b0, 128'h0, 1'b1, 1'b0, 32'h0,         5'd0, 1'b1};

    // Asynchronous reset before any clock edge
    #1 reset_n_i = 1'b0;
    #2;
    chk("reset_axil_req_v", 128'(axil_req_v_o), 128'(0));
    chk("reset_fifo_rsp_v", 128'(fifo_rsp_v_o), 128'(0));
    chk("reset_fifo_req_ready", 128'(fifo_req_ready_o), 128'(1));
    chk("reset_axil_rsp_ready", 128'(axil_rsp_ready_o), 128'(1));
    chk("reset_req_occ", 128'(req_occupancy_o), 128'(0));
    chk("reset_rsp_vac", 128'(rsp_vacancy_o), 128'(16));
    step(); step();
    reset_n_i = 1'b1;

    // Request serialization vectors
    for (int i = 0; i < 6; i++) begin
      fifo_req_v_i     = tbl[i].req_v;
      fifo_req_i       = tbl[i].req_data;
      axil_req_ready_i = tbl[i].host_rdy;
      if (tbl[i].req_v) push_req_words(tbl[i].req_data);
      @(negedge clk_i);
      chk($sformatf("vec%0d_req_v", i), 128'(axil_req_v_o), 128'(tbl[i].exp_v));
      if (tbl[i].exp_v) chk($sformatf("vec%0d_word", i), 128'(axil_req_o), 128'(tbl[i].exp_word));
      chk($sformatf("vec%0d_occ", i), 128'(req_occupancy_o), 128'(tbl[i].exp_occ));
      chk($sformatf("vec%0d_in_rdy", i), 128'(fifo_req_ready_o), 128'(tbl[i].exp_in_rdy));
      step();
    end

    // Request full with host stalled, then drain one packet and wrap
    axil_req_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fifo_req_v_i = 1'b1;
      fifo_req_i   = req_pkt(k);
      push_req_words(req_pkt(k));
      step();
    end
    fifo_req_i = req_pkt(4);
    push_req_words(req_pkt(4));
    @(negedge clk_i);
    chk("full_req_ready", 128'(fifo_req_ready_o), 128'(0));
    chk("full_req_occ", 128'(req_occupancy_o), 128'(16));
    step();
    axil_req_ready_i = 1'b1;
    waited = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (fifo_req_ready_o) break;
      waited++;
      step();
    end
    chk("full_stall_cycles", 128'(waited), 128'(4));
    chk("after_pop_occ", 128'(req_occupancy_o), 128'(12));
    step();
    fifo_req_v_i = 1'b0;
    drain_req(60);
    chk("req_drained", 128'(req_q.size()), 128'(0));
    chk("req_occ_empty", 128'(req_occupancy_o), 128'(0));
    step();
    axil_req_ready_i = 1'b0;

    // Response assembly under backpressure
    fifo_rsp_ready_i = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < 4; j++) begin
        axil_rsp_v_i = 1'b1;
        axil_rsp_i   = rsp_word(p, j);
        @(negedge clk_i);
        if (p == 0 && j == 3) chk("rsp_partial_hidden", 128'(fifo_rsp_v_o), 128'(0));
        if (p == 1 && j == 0) chk("rsp_commit_latency", 128'(fifo_rsp_v_o), 128'(1));
        step();
      end
      rsp_q.push_back(rsp_pkt(p));
    end
    axil_rsp_v_i = 1'b0;
    @(negedge clk_i);
    chk("two_pkts_vac", 128'(rsp_vacancy_o), 128'(8));
    step();
    fifo_rsp_ready_i = 1'b1;
    drain_rsp(30);
    chk("rsp_drained", 128'(rsp_q.size()), 128'(0));
    chk("rsp_vac_empty", 128'(rsp_vacancy_o), 128'(16));
    step();

    // Response full: a 17th word must be refused
    fifo_rsp_ready_i = 1'b0;
    for (int p = 2; p < 6; p++) write_rsp_pkt(p);
    axil_rsp_v_i = 1'b1;
    axil_rsp_i   = 32'hDEAD_BEEF;
    @(negedge clk_i);
    chk("rsp_full_ready", 128'(axil_rsp_ready_o), 128'(0));
    chk("rsp_full_vac", 128'(rsp_vacancy_o), 128'(0));
    step();
    axil_rsp_v_i     = 1'b0;
    fifo_rsp_ready_i = 1'b1;
    step();
    fifo_rsp_ready_i = 1'b0;
    @(negedge clk_i);
    chk("one_pop_vac", 128'(rsp_vacancy_o), 128'(4));
    chk("one_pop_ready", 128'(axil_rsp_ready_o), 128'(1));
    step();
    write_rsp_pkt(6);
    fifo_rsp_ready_i = 1'b1;
    drain_rsp(40);
    chk("rsp_full_drained", 128'(rsp_q.size()), 128'(0));
    chk("rsp_full_vac_back", 128'(rsp_vacancy_o), 128'(16));
    step();

    // Reset in the middle of a partially written response packet
    for (int j = 0; j < 2; j++) begin
      axil_rsp_v_i = 1'b1;
      axil_rsp_i   = rsp_word(7, j);
      step();
    end
    axil_rsp_v_i = 1'b0;
    @(negedge clk_i);
    chk("partial_vac", 128'(rsp_vacancy_o), 128'(14));
    #1 reset_n_i = 1'b0;
    #1;
    chk("midreset_vac", 128'(rsp_vacancy_o), 128'(16));
    chk("midreset_rsp_v", 128'(fifo_rsp_v_o), 128'(0));
    chk("midreset_req_occ", 128'(req_occupancy_o), 128'(0));
    chk("midreset_rsp_ready", 128'(axil_rsp_ready_o), 128'(1));
    step();
    reset_n_i = 1'b1;
    write_rsp_pkt(8);
    drain_rsp(30);
    chk("post_reset_drained", 128'(rsp_q.size()), 128'(0));
    step(); step();
    @(negedge clk_i);
    chk("post_reset_one_pkt", 128'(fifo_rsp_v_o), 128'(0));
    chk("post_reset_vac", 128'(rsp_vacancy_o), 128'(16));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bsg_mcl_axil_fifos_slave.md
Name: bsg_mcl_axil_fifos_slave

Overview:
- Host-side adapter for manycore-initiated traffic, paired with the host master FIFO adapter.
- Request path: buffers full-width manycore request packets arriving from the endpoint and serializes each one into AXI-Lite-width words for the host to read.
- Response path: deserializes host-written AXI-Lite words into full-width response packets toward the endpoint.
- Publishes word-granular occupancy and vacancy counts so host software can poll before each access.

Parameters:
- fifo_width_p, 128, packet width on the endpoint side; must be a multiple of axil_data_width_p.
- axil_data_width_p, 32, host word width.
- req_els_p, 4, request packet buffer depth (≥1).
- rsp_els_p, 4, response packet buffer depth (≥1).
- ratio_lp (localparam) = fifo_width_p/axil_data_width_p.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_n_i  in  1  reset, asynchronous and active-low.
- fifo_req_i  in  fifo_width_p  request packet from the endpoint.
- fifo_req_v_i  in  1  request valid.
- fifo_req_ready_o  out  1  request buffer can accept a packet.
- axil_req_o  out  axil_data_width_p  current request word for the host.
- axil_req_v_o  out  1  request word available.
- axil_req_ready_i  in  1  host consumes the current word.
- axil_rsp_i  in  axil_data_width_p  response word written by the host.
- axil_rsp_v_i  in  1  response word valid.
- axil_rsp_ready_o  out  1  response buffer can accept a word.
- fifo_rsp_o  out  fifo_width_p  assembled response packet.
- fifo_rsp_v_o  out  1  response packet valid.
- fifo_rsp_ready_i  in  1  endpoint accepts the packet.
- req_occupancy_o  out  BSG_WIDTH(ratio_lp*req_els_p)  request words readable by the host.
- rsp_vacancy_o  out  BSG_WIDTH(ratio_lp*rsp_els_p)  response words writable by the host.

Behaviour:
- Handshakes are valid/ready.
  - A transfer occurs on a cycle where v and ready are both high.
  - Ready outputs never depend combinationally on valid inputs.
- Reset (reset_n_i low, asynchronous):
  - Clears all pointers, packet counts and word indices.
  - Output values: axil_req_v_o=0, fifo_rsp_v_o=0, fifo_req_ready_o=1, axil_rsp_ready_o=1, req_occupancy_o=0, rsp_vacancy_o=ratio_lp*rsp_els_p.
  - Data outputs are don't-care while the matching valid is low.
  - Reset mid-operation discards all buffered and partially transferred packets. No partial packet survives.
- Request buffer: circular, req_els_p entries, with write pointer, read pointer and count req_cnt (0..req_els_p).
  - fifo_req_ready_o = (req_cnt != req_els_p).
  - Registered decision: does not account for a same-cycle pop, so a full buffer stalls one cycle after draining.
- Request serializer: word index rd_idx (0..ratio_lp-1).
  - axil_req_o = bits [(rd_idx+1)*axil_data_width_p-1 : rd_idx*axil_data_width_p] of the head packet, least-significant word first.
  - axil_req_v_o = (req_cnt != 0).
  - On a host transfer with rd_idx < ratio_lp-1: rd_idx increments.
  - On a host transfer with rd_idx = ratio_lp-1: rd_idx returns to 0, the head is popped and the read pointer advances (wrapping at req_els_p).
- Request latency: a packet accepted in cycle t shows axil_req_v_o=1 in cycle t+1 when the buffer was empty.
- Simultaneous packet push and final-word pop: req_cnt is unchanged and both pointers advance.
- req_occupancy_o = req_cnt*ratio_lp - rd_idx, registered or derived from registered state.
- Response assembler: buffer of rsp_els_p entries with committed count rsp_cnt, write pointer, and word index wr_idx.
  - axil_rsp_ready_o = (rsp_cnt != rsp_els_p).
  - Each accepted word is written into slice wr_idx of the entry at the write pointer, then wr_idx increments.
  - On the word with wr_idx = ratio_lp-1: the entry commits, rsp_cnt increments, wr_idx returns to 0, and the write pointer advances with wrap.
  - A partial entry is never visible on fifo_rsp_o.
- Response output:
  - fifo_rsp_v_o = (rsp_cnt != 0); fifo_rsp_o = the entry at the read pointer.
  - A transfer to the endpoint pops the entry.
  - Commit and pop in the same cycle leave rsp_cnt unchanged.
  - A last word written in cycle t gives fifo_rsp_v_o=1 in cycle t+1.
- rsp_vacancy_o = (rsp_els_p - rsp_cnt)*ratio_lp - wr_idx.
- ratio_lp = 1: the word indices stay at 0 and the block degenerates to two FIFOs.
- Simulation-only check: fatal error if fifo_width_p is not a multiple of axil_data_width_p, or if either depth parameter is 0.

Test Plan:
- Reset check: assert reset_n_i low asynchronously between clock edges → outputs take their reset values immediately; rsp_vacancy_o=16 and req_occupancy_o=0 with defaults.
- Request serialization: push packet 128'h4444_4444_3333_3333_2222_2222_1111_1111 with axil_req_ready_i held high → words 1111_1111, 2222_2222, 3333_3333, 4444_4444 on four consecutive cycles starting at t+1; req_occupancy_o steps 4,3,2,1,0.
- Request full and wrap: push 5 packets with the host stalled → 4 accepted, fifo_req_ready_o=0, req_occupancy_o=16. Drain 1 packet → ready returns. The 5th packet is read after the 4 earlier ones, in order, through the pointer wrap.
- Response assembly under backpressure: write 8 words with fifo_rsp_ready_i=0 → two packets commit, rsp_vacancy_o=8. Release ready → packets emerge in order with word 0 in bits [31:0].
- Response full: write 16 words with fifo_rsp_ready_i=0 → axil_rsp_ready_o=0 after the 16th word and a 17th word is not accepted. One endpoint pop → vacancy 4.
- Reset mid-packet: write 2 response words, assert reset, write 4 more → exactly one packet, containing only the post-reset words.
